param_up_down_counter: RTL and testbench
========================================

// Module: param_up_down_counter
// PURPOSE
//  Parametrised up/down counter with parallel load, run-time upper limit, wrap or saturate mode,
//  terminal-count strobe and sticky overflow/underflow flags. Generalises the 3-bit up/down counter
//  for timer, address-sequencer and event-count duties. Single clock domain, synchronous reset.
// PARAMETERS
//  WIDTH     8   counter width in bits (>=2)
//  PRESCALE  4   enabled cycles per count step; used only when UDC_PRESCALE_EN is defined (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous active-high reset
//  load        in   1      load Data_in on next edge; highest priority after reset
//  Data_in     in   WIDTH  parallel load value
//  counter_on  in   1      count enable
//  count_up    in   1      1 = increment, 0 = decrement
//  sat_mode    in   1      1 = saturate at bounds, 0 = wrap
//  limit       in   WIDTH  inclusive upper bound; count range 0..limit
//  clr_flags   in   1      clear ovf/udf
//  Count       out  WIDTH  registered count
//  tc          out  1      combinational terminal-count strobe
//  ovf         out  1      sticky overflow flag (registered)
//  udf         out  1      sticky underflow flag (registered)
// BEHAVIOUR
//  - Priority per edge: reset > load > step > hold. All state updates on posedge clk only.
//  - reset=1: Count=0, ovf=0, udf=0, prescaler=0. No async path.
//  - load=1: Count = (Data_in > limit) ? limit : Data_in. No step, no flag change, prescaler cleared.
//  - step = counter_on & ~load (without UDC_PRESCALE_EN); latency 1 clock, Count visible next cycle.
//  - Up step: Count < limit -> Count+1. Count >= limit -> wrap: 0; sat: limit. ovf set.
//  - Down step: Count > limit -> Count = limit (no flag). Count == 0 -> wrap: limit; sat: 0. udf set.
//    Otherwise Count-1.
//  - limit lowered below Count while idle: Count holds; next step resolves as above.
//  - limit == 0: Count held at 0; every up step sets ovf, every down step sets udf.
//  - tc = step & ((count_up & Count>=limit) | (~count_up & Count==0)); high exactly in the cycle
//    whose edge produces the wrap/saturate.
//  - Flags: set by event, cleared by clr_flags; event and clr_flags same cycle -> flag set (set wins).
//  - Arithmetic is modulo 2^WIDTH internally; compares unsigned; no X on any output after reset.
// CONFIGURATION
//  - UDC_PRESCALE_EN defined: internal counter ps (ceil(log2(PRESCALE)) bits) increments on
//    counter_on & ~load; step fires only when ps == PRESCALE-1 (ps then returns to 0); tc gated
//    by the same condition. ps cleared by reset and load; holds when counter_on=0.
//  - UDC_PRESCALE_EN undefined: no ps register; PRESCALE ignored; step every enabled cycle.
// TESTING
//  1. WIDTH=8, limit=5, wrap, reset then counter_on=1,up 7 clks -> Count 1,2,3,4,5,0,1; tc high
//     once (Count=5 cycle); ovf=1.
//  2. limit=5, sat, load Data_in=9 -> Count=5; down 6 clks -> 4,3,2,1,0,0; udf=1; tc on last cycle.
//  3. Count=3, load=1 & counter_on=1 & count_up=1, Data_in=2 -> Count=2 (load wins), flags unchanged.
//  4. ovf=1, up step at limit with clr_flags=1 -> ovf stays 1; next cycle clr_flags=1, idle -> ovf=0.
//  5. Mid-count (Count=4) assert reset with counter_on=1 -> next edge Count=0, ovf=udf=0; reset
//     asserted between edges has no effect until edge.
//  6. UDC_PRESCALE_EN, PRESCALE=4, limit=255, up -> Count increments every 4th cycle (8 clks -> 2);
//     counter_on dropped mid-period resumes without losing ps phase.

Source files
------------

// File: rtl/param_up_down_counter.sv
// param_up_down_counter
//   Parametrised up/down counter with parallel load, run-time inclusive upper
//   limit, wrap or saturate behaviour at the bounds, a combinational
//   terminal-count strobe and sticky overflow/underflow flags.
//   Optional feature macro: UDC_PRESCALE_EN. When defined, an internal
//   prescaler divides enabled cycles by PRESCALE before each count step.
//   Priority per clock edge: reset > load > step > hold.
module param_up_down_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             counter_on,
    input  logic             count_up,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] Count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    // Elaboration-time sanity checks on the parameters.
    if (WIDTH < 2) begin : g_width_check
        $error("param_up_down_counter: WIDTH must be >= 2");
    end
    if (PRESCALE < 2) begin : g_prescale_check
        $error("param_up_down_counter: PRESCALE must be >= 2");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             step;
    logic             ovf_evt;
    logic             udf_evt;

`ifdef UDC_PRESCALE_EN
    localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler phase: advances on enabled cycles, wraps after the last phase, cleared by load.
    always_comb begin
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (counter_on) begin
            ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
        end
    end

    // Prescaler phase register; holds while counter_on is low so the phase is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // A count step happens only on the enabled cycle that completes a prescale period.
    always_comb begin
        step = counter_on & ~load & (ps_q == PS_LAST);
    end
`else
    // Without the prescaler every enabled, non-load cycle is a count step.
    always_comb begin
        step = counter_on & ~load;
    end
`endif

    // Next count: clamped load, otherwise an up/down step with wrap or saturate at the bounds.
    always_comb begin
        count_d = count_q;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        if (load) begin
            count_d = (Data_in > limit) ? limit : Data_in;
        end else if (step) begin
            if (count_up) begin
                // At or above the limit (limit may have been lowered while idle) is an overflow.
                if (count_q >= limit) begin
                    count_d = sat_mode ? limit : '0;
                    ovf_evt = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                // Above the limit pulls back to the limit without flagging; zero is an underflow.
                if (count_q > limit) begin
                    count_d = limit;
                end else if (count_q == '0) begin
                    count_d = sat_mode ? '0 : limit;
                    udf_evt = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Sticky flags: an event in the same cycle as clr_flags keeps the flag set.
    always_comb begin
        ovf_d = (ovf_q & ~clr_flags) | ovf_evt;
        udf_d = (udf_q & ~clr_flags) | udf_evt;
    end

    // Count and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Terminal count is high in exactly the cycle whose edge wraps or saturates.
    always_comb begin
        tc = step & ((count_up & (count_q >= limit)) | (~count_up & (count_q == '0)));
    end

    assign Count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed self-checking bench for param_up_down_counter (WIDTH=8, PRESCALE=4).
// Inputs change on the falling edge; outputs are checked on the falling edge,
// and the combinational tc is checked just before the rising edge it qualifies.
module tb_param_up_down_counter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] Data_in;
    logic             counter_on;
    logic             count_up;
    logic             sat_mode;
    logic [WIDTH-1:0] limit;
    logic             clr_flags;
    logic [WIDTH-1:0] Count;
    logic             tc;
    logic             ovf;
    logic             udf;

    int vectors     = 0;
    int miscompares = 0;

    param_up_down_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .Data_in    (Data_in),
        .counter_on (counter_on),
        .count_up   (count_up),
        .sat_mode   (sat_mode),
        .limit      (limit),
        .clr_flags  (clr_flags),
        .Count      (Count),
        .tc         (tc),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle inputs, leaving limit and mode as they are.
    task automatic idle();
        reset      = 1'b0;
        load       = 1'b0;
        counter_on = 1'b0;
        clr_flags  = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        idle();
        load    = 1'b1;
        Data_in = v;
        tick();
        load    = 1'b0;
    endtask

    initial begin
        int exp_up[7];
        int exp_dn[6];
        int prev;

        reset      = 1'b1;
        load       = 1'b0;
        Data_in    = '0;
        counter_on = 1'b0;
        count_up   = 1'b1;
        sat_mode   = 1'b0;
        limit      = 8'd5;
        clr_flags  = 1'b0;
        tick();
        chk("reset_count", 32'(Count), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_udf", 32'(udf), 0);

`ifndef UDC_PRESCALE_EN
        // Wrap up-count to limit 5.
        exp_up = '{1, 2, 3, 4, 5, 0, 1};
        idle();
        counter_on = 1'b1;
        count_up   = 1'b1;
        sat_mode   = 1'b0;
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("up_wrap_tc%0d", i), 32'(tc), (prev == 5) ? 1 : 0);
            tick();
            chk($sformatf("up_wrap_cnt%0d", i), 32'(Count), 32'(exp_up[i]));
            prev = exp_up[i];
        end
        chk("up_wrap_ovf", 32'(ovf), 1);
        chk("up_wrap_udf", 32'(udf), 0);

        // Saturating down-count after a clamped load.
        sat_mode = 1'b1;
        do_load(8'd9);
        chk("load_clamp", 32'(Count), 5);
        exp_dn = '{4, 3, 2, 1, 0, 0};
        counter_on = 1'b1;
        count_up   = 1'b0;
        prev = 5;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("dn_sat_tc%0d", i), 32'(tc), (prev == 0) ? 1 : 0);
            tick();
            chk($sformatf("dn_sat_cnt%0d", i), 32'(Count), 32'(exp_dn[i]));
            prev = exp_dn[i];
        end
        chk("dn_sat_udf", 32'(udf), 1);

        // Load beats a simultaneous step; flags untouched.
        do_load(8'd3);
        chk("load3", 32'(Count), 3);
        load       = 1'b1;
        counter_on = 1'b1;
        count_up   = 1'b1;
        Data_in    = 8'd2;
        #1;
        chk("load_step_tc", 32'(tc), 0);
        tick();
        chk("load_wins", 32'(Count), 2);
        chk("load_ovf_kept", 32'(ovf), 1);
        chk("load_udf_kept", 32'(udf), 1);

        // Flag set wins over a same-cycle clear.
        idle();
        clr_flags = 1'b1;
        tick();
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_udf", 32'(udf), 0);
        do_load(8'd5);
        counter_on = 1'b1;
        count_up   = 1'b1;
        tick();
        chk("sat_top_cnt", 32'(Count), 5);
        chk("sat_top_ovf", 32'(ovf), 1);
        clr_flags = 1'b1;
        tick();
        chk("set_wins_ovf", 32'(ovf), 1);
        chk("set_wins_cnt", 32'(Count), 5);
        idle();
        clr_flags = 1'b1;
        tick();
        chk("clear_after", 32'(ovf), 0);

        // Reset mid-count clears count and both flags, only at the edge.
        sat_mode = 1'b0;
        do_load(8'd5);
        counter_on = 1'b1;
        count_up   = 1'b1;
        tick();
        chk("wrap_to0", 32'(Count), 0);
        count_up = 1'b0;
        tick();
        chk("dn_wrap_lim", 32'(Count), 5);
        chk("dn_wrap_udf", 32'(udf), 1);
        tick();
        chk("mid_count", 32'(Count), 4);
        counter_on = 1'b0;
        @(posedge clk);
        #2;
        reset      = 1'b1;
        counter_on = 1'b1;
        count_up   = 1'b1;
        #1;
        chk("reset_no_async", 32'(Count), 4);
        @(negedge clk);
        tick();
        chk("rst_mid_cnt", 32'(Count), 0);
        chk("rst_mid_ovf", 32'(ovf), 0);
        chk("rst_mid_udf", 32'(udf), 0);

        // Limit lowered below the count while idle.
        idle();
        limit = 8'd255;
        do_load(8'd200);
        limit = 8'd10;
        tick();
        chk("lowered_hold", 32'(Count), 200);
        counter_on = 1'b1;
        count_up   = 1'b0;
        #1;
        chk("lowered_dn_tc", 32'(tc), 0);
        tick();
        chk("lowered_dn_cnt", 32'(Count), 10);
        chk("lowered_dn_udf", 32'(udf), 0);
        idle();
        do_load(8'd10);
        limit = 8'd3;
        counter_on = 1'b1;
        count_up   = 1'b1;
        #1;
        chk("lowered_up_tc", 32'(tc), 1);
        tick();
        chk("lowered_up_cnt", 32'(Count), 0);
        chk("lowered_up_ovf", 32'(ovf), 1);

        // limit == 0 keeps the count at zero and flags every step.
        idle();
        clr_flags = 1'b1;
        tick();
        limit      = 8'd0;
        clr_flags  = 1'b0;
        counter_on = 1'b1;
        count_up   = 1'b0;
        tick();
        chk("lim0_dn_cnt", 32'(Count), 0);
        chk("lim0_dn_udf", 32'(udf), 1);
        chk("lim0_dn_ovf", 32'(ovf), 0);
        count_up = 1'b1;
        sat_mode = 1'b1;
        tick();
        chk("lim0_up_cnt", 32'(Count), 0);
        chk("lim0_up_ovf", 32'(ovf), 1);
`else
        // Prescaled up-count: one step per four enabled cycles.
        idle();
        limit      = 8'd255;
        count_up   = 1'b1;
        counter_on = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("ps_cnt%0d", i), 32'(Count), 32'(i / 4));
        end
        // Two enabled cycles, pause, then the period finishes after two more.
        tick();
        tick();
        chk("ps_part", 32'(Count), 2);
        counter_on = 1'b0;
        tick();
        tick();
        tick();
        chk("ps_hold", 32'(Count), 2);
        counter_on = 1'b1;
        tick();
        chk("ps_resume1", 32'(Count), 2);
        tick();
        chk("ps_resume2", 32'(Count), 3);
        // Load clears the phase: next step needs a full period again.
        do_load(8'd254);
        counter_on = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("ps_afterload%0d", i), 32'(Count), 254);
        end
        tick();
        chk("ps_step255", 32'(Count), 255);
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("ps_tc_gated%0d", i), 32'(tc), 0);
            tick();
        end
        #1;
        chk("ps_tc", 32'(tc), 1);
        tick();
        chk("ps_wrap", 32'(Count), 0);
        chk("ps_ovf", 32'(ovf), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
